memory_arbiter: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/memory_arbiter.sv | 156 +++++++++++++++
 tb/tb_memory_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t      : 32-bit machine word
//   ramstate_t  : status reported by the single-ported RAM
//   arb_state_t : states of the RAM arbiter between fetch and data ports
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between the instruction-fetch
// port and the data port. One requester is granted at a time. The grant is held
// until the RAM reports ACCESS, the request is withdrawn, the RAM reports ERROR,
// or the watchdog expires. Data has priority. Fetch is forced once STARVE_LIMIT
// consecutive data hits have completed while a fetch was waiting.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | RAM outputs idle, arbitrate; winner is granted next cycle
// GRANT_I | fetch port drives the RAM, waits for ACCESS
// GRANT_D | data port drives the RAM, waits for ACCESS
//
// Ports:
//   CLK, nRST                 clock, async active-low reset
//   iREN, iaddr               fetch request / address
//   dREN, dWEN, daddr, dstore data read / write request, address, store data
//   ihit, iload               fetch complete this cycle / fetched word
//   dhit, dload               data complete this cycle / loaded word
//   ramREN, ramWEN, ramaddr, ramstore  RAM request side
//   ramload, ramstate         RAM response side
//   bus_err                   one-cycle pulse on watchdog timeout or RAM ERROR
//
// STARVE_LIMIT must be <= 7, because the starvation counter is 3 bits wide.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        bus_err
);

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_MAX   = 8'(TIMEOUT);

    arb_state_t state, next_state;
    ramstate_t  ram_st;
    logic [7:0] wait_cnt;
    logic [2:0] starve_cnt;

    assign ram_st = ramstate_t'(ramstate);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        dhit       = 1'b0;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        bus_err    = 1'b0;

        case (state)
            IDLE: begin
                if (iREN && (starve_cnt == STARVE_MAX)) begin
                    next_state = GRANT_I;
                end else if (dREN || dWEN) begin
                    next_state = GRANT_D;
                end else if (iREN) begin
                    next_state = GRANT_I;
                end
            end

            GRANT_I: begin
                // A withdrawn request releases the RAM in the same cycle.
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_st == ACCESS) begin
                        ihit       = 1'b1;
                        iload      = ramload;
                        next_state = IDLE;
                    end else if ((ram_st == ERROR) || (wait_cnt == WAIT_MAX)) begin
                        bus_err    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end

            GRANT_D: begin
                if (!(dREN || dWEN)) begin
                    next_state = IDLE;
                end else begin
                    // A read wins if both a read and a write are requested.
                    ramREN   = dREN;
                    ramWEN   = dWEN & ~dREN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ram_st == ACCESS) begin
                        dhit       = 1'b1;
                        dload      = ramload;
                        next_state = IDLE;
                    end else if ((ram_st == ERROR) || (wait_cnt == WAIT_MAX)) begin
                        bus_err    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end

            default: next_state = IDLE;
        endcase
    end

    // Every grant is entered from IDLE, so holding the counter at zero in IDLE
    // is the same as clearing it on entry to a grant state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (!iREN || ihit) begin
            starve_cnt <= '0;
        end else if (dhit && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter. The bench pushes each completion event
// it expects (ihit, dhit or bus_err, plus its data) onto a queue when it drives
// the stimulus. A negedge monitor pops and compares an entry whenever the DUT
// signals an event. Scenario code also checks the RAM-side outputs directly.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam logic [2:0] K_I = 3'b001;
    localparam logic [2:0] K_D = 3'b010;
    localparam logic [2:0] K_E = 3'b100;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] data;
    } evt_t;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        bus_err;

    int   n_cmp = 0;
    int   n_err = 0;
    evt_t exp_q[$];
    evt_t mon_e;
    logic [31:0] mon_data;

    memory_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .ihit     (ihit),
        .dhit     (dhit),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .bus_err  (bus_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_evt(input logic [2:0] k, input logic [31:0] d);
        evt_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            if (!ihit) check_val("iload_quiet", iload, 32'h0);
            if (!dhit) check_val("dload_quiet", dload, 32'h0);
            if (ihit || dhit || bus_err) begin
                mon_data = ihit ? iload : (dhit ? dload : 32'h0);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_evt", {29'b0, bus_err, dhit, ihit}, 32'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("evt_kind", {29'b0, bus_err, dhit, ihit}, {29'b0, mon_e.kind});
                    check_val("evt_data", mon_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

        // reset state
        @(negedge CLK);
        check_val("rst_flags", {27'b0, ihit, dhit, bus_err, ramREN, ramWEN}, 32'h0);
        check_val("rst_addr", ramaddr, 32'h0);
        tick();
        nRST = 1'b1;

        // S1: fetch only, three BUSY cycles then ACCESS
        iREN = 1'b1; iaddr = 32'h40;
        @(negedge CLK); check_val("s1_idle_ren", ramREN, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            ramstate = BUSY;
            @(negedge CLK);
            check_val("s1_ren", ramREN, 1'b1);
            check_val("s1_addr", ramaddr, 32'h40);
            tick();
        end
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        expect_evt(K_I, 32'hDEADBEEF);
        @(negedge CLK); check_val("s1_acc_ren", ramREN, 1'b1);
        tick();
        iREN = 1'b0; ramstate = FREE; ramload = '0;
        @(negedge CLK); check_val("s1_back_idle", ramREN, 1'b0);
        tick();

        // S2: fetch and data write together; data first, dead cycle, then fetch
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234;
        @(negedge CLK); check_val("s2_idle_wen", ramWEN, 1'b0);
        tick();
        ramstate = ACCESS; ramload = 32'hCAFE0001;
        expect_evt(K_D, 32'hCAFE0001);
        @(negedge CLK);
        check_val("s2_wen", ramWEN, 1'b1);
        check_val("s2_ren", ramREN, 1'b0);
        check_val("s2_addr", ramaddr, 32'h100);
        check_val("s2_store", ramstore, 32'h1234);
        tick();
        dWEN = 1'b0; ramstate = FREE;
        @(negedge CLK); check_val("s2_dead_ren", ramREN, 1'b0);
        tick();
        ramstate = ACCESS; ramload = 32'h11112222;
        expect_evt(K_I, 32'h11112222);
        @(negedge CLK);
        check_val("s2_i_ren", ramREN, 1'b1);
        check_val("s2_i_addr", ramaddr, 32'h44);
        tick();
        iREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        tick();

        // S3: fetch starved by continuous data reads, forced after 4 data hits
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            daddr = 32'h200 + 32'(4 * k);
            ramstate = FREE;
            @(negedge CLK); check_val("s3_idle", ramREN, 1'b0);
            tick();
            ramstate = ACCESS; ramload = 32'hA0000000 + 32'(k);
            expect_evt(K_D, 32'hA0000000 + 32'(k));
            @(negedge CLK); check_val("s3_d_addr", ramaddr, 32'h200 + 32'(4 * k));
            tick();
        end
        ramstate = FREE;
        @(negedge CLK); check_val("s3_idle_last", ramREN, 1'b0);
        tick();
        ramstate = ACCESS; ramload = 32'hB0B00000;
        expect_evt(K_I, 32'hB0B00000);
        @(negedge CLK); check_val("s3_forced_i", ramaddr, 32'h80);
        tick();
        ramstate = FREE; daddr = 32'h210;
        @(negedge CLK);
        tick();
        ramstate = ACCESS; ramload = 32'hA0000010;
        expect_evt(K_D, 32'hA0000010);
        @(negedge CLK); check_val("s3_d_after_clear", ramaddr, 32'h210);
        tick();
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        tick();

        // S4: data read withdrawn while BUSY
        dREN = 1'b1; daddr = 32'h300;
        @(negedge CLK);
        tick();
        ramstate = BUSY;
        @(negedge CLK); check_val("s4_busy_ren", ramREN, 1'b1);
        tick();
        dREN = 1'b0;
        @(negedge CLK); check_val("s4_abort_ren", ramREN, 1'b0);
        tick();
        dREN = 1'b1; ramstate = FREE;
        @(negedge CLK); check_val("s4_idle_after", ramREN, 1'b0);
        tick();
        ramstate = ACCESS; ramload = 32'h3333;
        expect_evt(K_D, 32'h3333);
        @(negedge CLK); check_val("s4_regrant", ramREN, 1'b1);
        tick();
        dREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        tick();

        // S5: RAM stuck BUSY, watchdog fires on the 9th grant cycle
        iREN = 1'b1; iaddr = 32'h500;
        @(negedge CLK);
        tick();
        ramstate = BUSY;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            check_val("s5_wait_ren", ramREN, 1'b1);
            check_val("s5_no_err", bus_err, 1'b0);
            tick();
        end
        expect_evt(K_E, 32'h0);
        @(negedge CLK); check_val("s5_to_ren", ramREN, 1'b1);
        tick();
        @(negedge CLK); check_val("s5_idle_after_to", ramREN, 1'b0);
        tick();
        ramstate = ACCESS; ramload = 32'h5555;
        expect_evt(K_I, 32'h5555);
        @(negedge CLK);
        tick();
        iREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        tick();

        // S5b: RAM reports ERROR during a data grant
        dREN = 1'b1; daddr = 32'h600;
        @(negedge CLK);
        tick();
        ramstate = ERROR;
        expect_evt(K_E, 32'h0);
        @(negedge CLK);
        tick();
        dREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        tick();

        // S6: reset asserted mid GRANT_D
        dREN = 1'b1; daddr = 32'h700;
        @(negedge CLK);
        tick();
        ramstate = BUSY;
        @(negedge CLK); check_val("s6_pre_ren", ramREN, 1'b1);
        tick();
        #2;
        nRST = 1'b0; ramstate = ACCESS;
        #1;
        check_val("s6_rst_flags", {27'b0, ihit, dhit, bus_err, ramREN, ramWEN}, 32'h0);
        check_val("s6_rst_addr", ramaddr, 32'h0);
        @(negedge CLK);
        tick();
        ramstate = FREE; nRST = 1'b1;
        @(negedge CLK); check_val("s6_first_idle", ramREN, 1'b0);
        tick();
        ramstate = ACCESS; ramload = 32'h7777;
        expect_evt(K_D, 32'h7777);
        @(negedge CLK);
        check_val("s6_grant_ren", ramREN, 1'b1);
        check_val("s6_grant_addr", ramaddr, 32'h700);
        tick();
        dREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        tick();

        check_val("q_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
